main_call_launcher: RTL

//  Upstream launcher for the generated `main` component (UTF-8 to wide-char converter).

---
 rtl/main_call_launcher_if.sv | 49 ++++
 rtl/main_call_launcher.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/main_call_launcher_if.sv
// Host command/response bus and the call/return handshake towards the `main` component.
// The launcher takes the slave view; the host and the component take the master view.
interface main_call_launcher_if #(
   parameter int unsigned ARG_W = 64,
   parameter int unsigned RET_W = 32,
   parameter int unsigned CYC_W = 32,
   parameter int unsigned TO_W  = 24
);
   // host command side
   logic             cmd_valid;
   logic             cmd_ready;
   logic [ARG_W-1:0] cmd_einval;
   logic [ARG_W-1:0] cmd_errno;
   logic [TO_W-1:0]  timeout_limit;

   // host response side
   logic             rsp_valid;
   logic             rsp_ready;
   logic [RET_W-1:0] rsp_data;
   logic             rsp_timeout;
   logic [CYC_W-1:0] rsp_cycles;

   // component call/return side
   logic             start;
   logic             busy;
   logic [ARG_W-1:0] EINVAL;
   logic [ARG_W-1:0] errno;
   logic             done;
   logic             stall;
   logic [RET_W-1:0] returndata;

   modport slave (
      input  cmd_valid, cmd_einval, cmd_errno, timeout_limit,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_timeout, rsp_cycles,
      input  rsp_ready,
      output start, EINVAL, errno, stall,
      input  busy, done, returndata
   );

   modport master (
      output cmd_valid, cmd_einval, cmd_errno, timeout_limit,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_timeout, rsp_cycles,
      output rsp_ready,
      input  start, EINVAL, errno, stall,
      output busy, done, returndata
   );
endinterface

// File: rtl/main_call_launcher.sv
// Launches calls into the `main` component, times them, applies an optional watchdog,
// holds one response for the host and drains completions orphaned by a watchdog expiry.
module main_call_launcher #(
   parameter int unsigned ARG_W  = 64,
   parameter int unsigned RET_W  = 32,
   parameter int unsigned CYC_W  = 32,
   parameter int unsigned TO_W   = 24,
   parameter int unsigned STAT_W = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   main_call_launcher_if.slave  bus,
   output logic [STAT_W-1:0]    stat_calls,
   output logic [STAT_W-1:0]    stat_timeouts
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   logic [ARG_W-1:0] einval_q;
   logic [ARG_W-1:0] errno_q;
   logic [TO_W-1:0]  limit_q;
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] cyc_inc;
   logic [CYC_W-1:0] limit_ext;
   logic             hit_limit;

   logic             rsp_valid_q;
   logic [RET_W-1:0] rsp_data_q;
   logic             rsp_timeout_q;
   logic [CYC_W-1:0] rsp_cycles_q;
   logic             orphan;

   logic             accept;
   logic             call_done;
   logic             call_timeout;
   logic             orphan_set;
   logic             orphan_clr;

   // Saturating cycle count and watchdog compare; cyc+1 is also the reported duration.
   always_comb begin
      cyc_inc   = (cyc == '1) ? cyc : cyc + CYC_W'(1);
      limit_ext = CYC_W'(limit_q);
      hit_limit = (limit_q != '0) && (cyc_inc == limit_ext);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      call_done    = 1'b0;
      call_timeout = 1'b0;
      orphan_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.cmd_valid && !orphan) begin
               accept    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!bus.busy) begin
               state_nxt = S_RUN;
            end else if (hit_limit) begin
               call_timeout = 1'b1;
               state_nxt    = S_RESP;
            end
         end
         S_RUN: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (bus.done) begin
               call_done = 1'b1;
               state_nxt = S_RESP;
            end else if (hit_limit) begin
               call_timeout = 1'b1;
               orphan_set   = 1'b1;
               state_nxt    = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // An orphan only exists outside RUN, so any done seen meanwhile belongs to it.
   assign orphan_clr = orphan && bus.done && (state != S_RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         einval_q      <= '0;
         errno_q       <= '0;
         limit_q       <= '0;
         cyc           <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_cycles_q  <= '0;
         orphan        <= 1'b0;
         stat_calls    <= '0;
         stat_timeouts <= '0;
      end else begin
         if (accept) begin
            einval_q <= bus.cmd_einval;
            errno_q  <= bus.cmd_errno;
            limit_q  <= bus.timeout_limit;
            cyc      <= '0;
         end else if (state == S_ISSUE || state == S_RUN) begin
            cyc <= cyc_inc;
         end

         if (call_done || call_timeout) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= call_done ? bus.returndata : '0;
            rsp_timeout_q <= call_timeout;
            rsp_cycles_q  <= cyc_inc;
            if (stat_calls != '1) begin
               stat_calls <= stat_calls + STAT_W'(1);
            end
            if (call_timeout && (stat_timeouts != '1)) begin
               stat_timeouts <= stat_timeouts + STAT_W'(1);
            end
         end else if (state == S_RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end

         if (orphan_set) begin
            orphan <= 1'b1;
         end else if (orphan_clr) begin
            orphan <= 1'b0;
         end
      end
   end

   assign bus.cmd_ready   = (state == S_IDLE) && !orphan;
   assign bus.start       = (state == S_ISSUE);
   assign bus.stall       = !((state == S_RUN) || orphan);
   assign bus.EINVAL      = einval_q;
   assign bus.errno       = errno_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.rsp_cycles  = rsp_cycles_q;

endmodule
